// File: rtl/dac_tx_feeder.sv
// Packs a 16-bit I/Q host word stream into 32-bit {I,Q} words for the dac_tx sample FIFO.
// Runs fixed-length bursts with watermark back-pressure, drain detection and underrun counting.
module dac_tx_feeder #(
    parameter int HIGH_WATER = 32000,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             burst_start,
    input  logic             burst_abort,
    output logic             burst_busy,
    output logic             burst_done,
    output logic [CNT_W-1:0] underrun_cnt,
    output logic [31:0]      fifo_data_in,
    output logic             fifo_we,
    input  logic [15:0]      fifo_data_cnt,
    input  logic             fifo_full,
    input  logic             fifo_empty,
    output logic [1:0]       state_dbg
);

    // Handshake: a host word transfers on every rising clk edge where in_valid && in_ready;
    // in_valid may be held or dropped freely, in_ready never depends on in_valid.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    localparam logic [15:0]      HW_CNT  = 16'(HIGH_WATER);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state, state_n;
    logic             half, half_n;
    logic [15:0]      i_hold, i_hold_n;
    logic [CNT_W-1:0] remaining, remaining_n;
    logic [31:0]      data_n;
    logic             we_n;
    logic             done_n;
    logic [CNT_W-1:0] underrun_n;

    logic empty_m, empty_s, empty_d;
    logic stall;
    logic accept;
    logic underrun_evt;

    // fifo_empty comes from the DAC clock domain; resynchronise before any use.
    always_ff @(posedge clk) begin
        if (reset) begin
            empty_m <= 1'b1;
            empty_s <= 1'b1;
            empty_d <= 1'b1;
        end else begin
            empty_m <= fifo_empty;
            empty_s <= empty_m;
            empty_d <= empty_s;
        end
    end

    assign stall        = fifo_full || (fifo_data_cnt >= HW_CNT);
    assign in_ready     = (state == STREAM) && !stall && (remaining != '0);
    assign accept       = in_valid && in_ready;
    assign burst_busy   = (state == STREAM) || (state == FLUSH);
    assign state_dbg    = state;
    assign underrun_evt = (state == STREAM) && empty_s && !empty_d;

    always_comb begin
        state_n     = state;
        half_n      = half;
        i_hold_n    = i_hold;
        remaining_n = remaining;
        data_n      = fifo_data_in;
        we_n        = 1'b0;
        done_n      = 1'b0;
        unique case (state)
            IDLE: begin
                // A coincident abort suppresses the start.
                if (burst_start && !burst_abort) begin
                    if (burst_len == '0) begin
                        done_n = 1'b1;
                    end else begin
                        state_n     = STREAM;
                        remaining_n = burst_len;
                        half_n      = 1'b0;
                    end
                end
            end
            STREAM: begin
                if (burst_abort) begin
                    state_n     = IDLE;
                    half_n      = 1'b0;
                    remaining_n = '0;
                end else if (accept) begin
                    if (!half) begin
                        i_hold_n = in_data;
                        half_n   = 1'b1;
                    end else begin
                        data_n      = {i_hold, in_data};
                        we_n        = 1'b1;
                        half_n      = 1'b0;
                        remaining_n = remaining - CNT_ONE;
                        if (remaining == CNT_ONE) begin
                            state_n = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                if (burst_abort) begin
                    state_n     = IDLE;
                    half_n      = 1'b0;
                    remaining_n = '0;
                end else if (empty_s) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Underrun counter saturates rather than wrapping so a long outage stays visible.
    always_comb begin
        underrun_n = underrun_cnt;
        if (underrun_evt && (underrun_cnt != '1)) begin
            underrun_n = underrun_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            half         <= 1'b0;
            i_hold       <= '0;
            remaining    <= '0;
            fifo_data_in <= '0;
            fifo_we      <= 1'b0;
            burst_done   <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            state        <= state_n;
            half         <= half_n;
            i_hold       <= i_hold_n;
            remaining    <= remaining_n;
            fifo_data_in <= data_n;
            fifo_we      <= we_n;
            burst_done   <= done_n;
            underrun_cnt <= underrun_n;
        end
    end

endmodule

// File: tb/tb_dac_tx_feeder.sv
// Directed-plus-random bench for dac_tx_feeder against a burst-level behavioural model.
module tb_dac_tx_feeder;

    localparam int CW = 4;
    localparam int HW = 32000;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   in_data;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] burst_len;
    logic          burst_start;
    logic          burst_abort;
    logic          burst_busy;
    logic          burst_done;
    logic [CW-1:0] underrun_cnt;
    logic [31:0]   fifo_data_in;
    logic          fifo_we;
    logic [15:0]   fifo_data_cnt;
    logic          fifo_full;
    logic          fifo_empty;
    logic [1:0]    state_dbg;

    dac_tx_feeder #(.HIGH_WATER(HW), .CNT_W(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .burst_len     (burst_len),
        .burst_start   (burst_start),
        .burst_abort   (burst_abort),
        .burst_busy    (burst_busy),
        .burst_done    (burst_done),
        .underrun_cnt  (underrun_cnt),
        .fifo_data_in  (fifo_data_in),
        .fifo_we       (fifo_we),
        .fifo_data_cnt (fifo_data_cnt),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .state_dbg     (state_dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: burst activity, samples left, pending I word, empty history.
    bit          m_stream, m_flush, m_have_i, m_we, m_done, m_acc;
    int          m_left, m_urun;
    logic [15:0] m_i;
    bit          e_hist[$];
    logic [31:0] exp_q[$];

    logic [15:0] word_q[$];
    logic [31:0] got_q[$];
    int          we_seen, done_seen;
    bit          busy_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_ready();
        return m_stream && !fifo_full && (int'(fifo_data_cnt) < HW) && (m_left != 0);
    endfunction

    task automatic model_update();
        bit rdy, es, ed;
        rdy = exp_ready();
        es  = e_hist[1];
        ed  = e_hist[2];
        m_acc  = 1'b0;
        m_we   = 1'b0;
        m_done = 1'b0;
        if (reset) begin
            m_stream = 0; m_flush = 0; m_have_i = 0; m_left = 0; m_urun = 0;
            e_hist = '{1'b1, 1'b1, 1'b1};
            exp_q.delete();
            return;
        end
        if (m_stream && es && !ed && m_urun < CNT_MAX) m_urun++;
        e_hist.push_front(fifo_empty);
        void'(e_hist.pop_back());
        if (!m_stream && !m_flush) begin
            if (burst_start && !burst_abort) begin
                if (burst_len == 0) m_done = 1'b1;
                else begin
                    m_stream = 1; m_left = int'(burst_len); m_have_i = 0;
                end
            end
        end else if (burst_abort) begin
            m_stream = 0; m_flush = 0; m_left = 0; m_have_i = 0;
        end else if (m_stream) begin
            if (in_valid && rdy) begin
                m_acc = 1'b1;
                if (!m_have_i) begin
                    m_i = in_data; m_have_i = 1;
                end else begin
                    exp_q.push_back({m_i, in_data});
                    m_we = 1'b1; m_have_i = 0; m_left--;
                    if (m_left == 0) begin
                        m_stream = 0; m_flush = 1;
                    end
                end
            end
        end else if (es) begin
            m_flush = 0; m_done = 1'b1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check("in_ready", in_ready, exp_ready());
        check("burst_busy", burst_busy, m_stream || m_flush);
        check("burst_done", burst_done, m_done);
        check("underrun_cnt", underrun_cnt, m_urun);
        check("fifo_we", fifo_we, m_we);
        if (m_we && exp_q.size() > 0) check("fifo_data_in", fifo_data_in, exp_q.pop_front());
        if (fifo_we) begin
            we_seen++;
            got_q.push_back(fifo_data_in);
        end
        if (burst_done) done_seen++;
        if (burst_busy) busy_seen = 1;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start_burst(input int len);
        burst_len   = CW'(len);
        burst_start = 1'b1;
        tick();
        burst_start = 1'b0;
    endtask

    // Offers word_q[0] until the model accepts n words; optional random valid and stall.
    task automatic feed(input int n, input bit rnd);
        int sent = 0;
        int guard = 0;
        while (sent < n && guard < 400 && word_q.size() > 0) begin
            in_data  = word_q[0];
            in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (rnd) begin
                fifo_full     = ($urandom_range(0, 3) == 0);
                fifo_data_cnt = 16'(HW - 2 + $urandom_range(0, 3));
            end
            tick();
            if (m_acc) begin
                sent++;
                void'(word_q.pop_front());
            end
            guard++;
        end
        in_valid      = 1'b0;
        fifo_full     = 1'b0;
        fifo_data_cnt = 16'd0;
        if (sent != n) check("feed_timeout", sent, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_we, base_done;
        logic [15:0] a, b;
        e_hist = '{1'b1, 1'b1, 1'b1};
        reset = 1; in_data = 0; in_valid = 0; burst_len = 0; burst_start = 0;
        burst_abort = 0; fifo_data_cnt = 0; fifo_full = 0; fifo_empty = 1;
        @(posedge clk);
        model_update();
        #1;
        tick();
        check("reset_data", fifo_data_in, 32'h0);
        check("reset_state", state_dbg, 2'd0);
        reset = 0;
        ticks(2);

        // 1: four-sample burst with continuous valid
        fifo_empty = 0;
        ticks(3);
        got_q.delete(); done_seen = 0;
        for (int k = 1; k <= 8; k++) word_q.push_back(16'(k * 16'h1111));
        start_burst(4);
        feed(8, 1'b0);
        ticks(5);
        check("t1_no_early_done", done_seen, 0);
        fifo_empty = 1;
        ticks(6);
        check("t1_done_once", done_seen, 1);
        check("t1_writes", got_q.size(), 4);
        if (got_q.size() == 4) begin
            check("t1_w0", got_q[0], 32'h11112222);
            check("t1_w1", got_q[1], 32'h33334444);
            check("t1_w2", got_q[2], 32'h55556666);
            check("t1_w3", got_q[3], 32'h77778888);
        end

        // 2: high-water stall then random back-pressure
        fifo_empty = 0;
        ticks(3);
        base_we = we_seen;
        for (int k = 0; k < 12; k++) word_q.push_back(16'($urandom));
        start_burst(6);
        feed(3, 1'b0);
        fifo_data_cnt = 16'(HW);
        in_data = word_q[0];
        in_valid = 1'b1;
        #1;
        check("t2_stall_ready", in_ready, 1'b0);
        ticks(3);
        check("t2_no_write_stalled", we_seen - base_we, 1);
        fifo_data_cnt = 16'(HW - 1);
        feed(9, 1'b1);
        ticks(2);
        check("t2_writes", we_seen - base_we, 6);
        fifo_empty = 1;
        ticks(5);

        // 3: underrun counting and saturation
        fifo_empty = 0;
        ticks(3);
        start_burst(10);
        ticks(2);
        for (int t = 0; t < 3; t++) begin
            fifo_empty = 1; ticks(3);
            fifo_empty = 0; ticks(3);
        end
        check("t3_three_underruns", underrun_cnt, 3);
        for (int t = 0; t < 14; t++) begin
            fifo_empty = 1; ticks(3);
            fifo_empty = 0; ticks(3);
        end
        fifo_empty = 1;
        ticks(6);
        check("t3_saturated", underrun_cnt, CNT_MAX);
        burst_abort = 1; tick(); burst_abort = 0;
        ticks(2);

        // 4: abort with a lone I pending, then a clean burst
        fifo_empty = 0;
        ticks(3);
        base_we = we_seen; base_done = done_seen;
        for (int k = 0; k < 3; k++) word_q.push_back(16'($urandom));
        start_burst(3);
        feed(3, 1'b0);
        burst_abort = 1; tick(); burst_abort = 0;
        ticks(3);
        check("t4_abort_writes", we_seen - base_we, 1);
        check("t4_abort_no_done", done_seen - base_done, 0);
        a = 16'($urandom); b = 16'($urandom);
        word_q.push_back(a); word_q.push_back(b);
        word_q.push_back(16'($urandom)); word_q.push_back(16'($urandom));
        got_q.delete();
        start_burst(2);
        feed(4, 1'b0);
        ticks(2);
        check("t4_restart_first", got_q.size() > 0 ? got_q[0] : 32'hx, {a, b});
        fifo_empty = 1;
        ticks(5);

        // 5: zero-length burst, start+abort together, start during STREAM
        base_done = done_seen; busy_seen = 0;
        start_burst(0);
        ticks(2);
        check("t5_zero_done", done_seen - base_done, 1);
        check("t5_zero_busy", busy_seen, 1'b0);
        burst_abort = 1;
        start_burst(3);
        burst_abort = 0;
        ticks(2);
        check("t5_start_abort_idle", burst_busy, 1'b0);
        fifo_empty = 0;
        ticks(3);
        base_we = we_seen;
        for (int k = 0; k < 12; k++) word_q.push_back(16'($urandom));
        start_burst(5);
        feed(2, 1'b0);
        start_burst(9);
        feed(8, 1'b0);
        in_valid = 1'b1;
        ticks(3);
        in_valid = 1'b0;
        check("t5_ignored_start_writes", we_seen - base_we, 5);
        word_q.delete();
        fifo_empty = 1;
        ticks(5);

        // 6: reset in STREAM and in FLUSH
        fifo_empty = 0;
        ticks(3);
        for (int k = 0; k < 8; k++) word_q.push_back(16'($urandom));
        start_burst(4);
        feed(3, 1'b0);
        reset = 1; tick();
        check("t6_stream_rst_data", fifo_data_in, 32'h0);
        check("t6_stream_rst_urun", underrun_cnt, 0);
        check("t6_stream_rst_state", state_dbg, 2'd0);
        reset = 0;
        word_q.delete();
        ticks(2);
        fifo_empty = 0;
        ticks(3);
        word_q.push_back(16'($urandom)); word_q.push_back(16'($urandom));
        start_burst(1);
        feed(2, 1'b0);
        ticks(2);
        check("t6_in_flush", burst_busy, 1'b1);
        reset = 1; tick();
        check("t6_flush_rst_data", fifo_data_in, 32'h0);
        check("t6_flush_rst_state", state_dbg, 2'd0);
        reset = 0;
        ticks(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
